led_pattern_ctrl: RTL and testbench

//  Board-level sequencer that drives the 8-bit o_reg LED bank and the led_don indicator.

---
 rtl/led_pattern_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: button-driven LED pattern sequencer.
//   clk_50mhz : system clock, rising edge
//   reset     : synchronous, active-high
//   bt        : raw push-button, active-low, asynchronous
//   sw_reg    : raw 3-bit mode select, asynchronous
//   o_reg     : registered LED pattern
//   led_don   : registered, 1 while running
// Each press walks the controller through IDLE -> RUN -> PAUSE -> RUN.
// While running, a prescaled tick steps the pattern selected on sw_reg.
module led_pattern_ctrl #(
  parameter int unsigned TICK_DIV     = 6_250_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned WIDTH        = 8
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             bt,
  input  logic [2:0]       sw_reg,
  output logic [WIDTH-1:0] o_reg,
  output logic             led_don
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);

  localparam logic [WIDTH-1:0] LSB      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB      = LSB << (WIDTH - 1);
  localparam logic [WIDTH-1:0] ALT_SEED = WIDTH'({(WIDTH + 1) / 2{2'b01}});

  localparam logic [2:0] M_OFF      = 3'd0;
  localparam logic [2:0] M_WALK_L   = 3'd1;
  localparam logic [2:0] M_WALK_R   = 3'd2;
  localparam logic [2:0] M_PINGPONG = 3'd3;
  localparam logic [2:0] M_COUNT    = 3'd4;
  localparam logic [2:0] M_BLINK    = 3'd5;
  localparam logic [2:0] M_FILL     = 3'd6;
  localparam logic [2:0] M_ALT      = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  logic          r_bt_s1;
  logic          r_bt_s2;
  logic [2:0]    r_sw_s1;
  logic [2:0]    r_sw_s2;
  logic          r_bt_db;
  logic [DW-1:0] r_db_cnt;
  logic          r_press;

  state_t        r_state;
  logic [TW-1:0] r_presc;
  logic [2:0]    r_cur_mode;
  logic          r_dir_l;

  logic             w_tick;
  logic [WIDTH-1:0] w_next;
  logic             w_next_dir_l;

  // Synchronisers and debounce: the level flips only after the synced input
  // has disagreed with it for DEBOUNCE_CYC consecutive cycles.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_bt_s1  <= 1'b1;
      r_bt_s2  <= 1'b1;
      r_sw_s1  <= 3'd0;
      r_sw_s2  <= 3'd0;
      r_bt_db  <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_bt_s1 <= bt;
      r_bt_s2 <= r_bt_s1;
      r_sw_s1 <= sw_reg;
      r_sw_s2 <= r_sw_s1;
      r_press <= 1'b0;
      if (r_bt_s2 == r_bt_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_bt_db  <= r_bt_s2;
        r_db_cnt <= '0;
        // Only the falling (pressed) edge produces a pulse.
        r_press  <= ~r_bt_s2;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  assign w_tick = (r_state == S_RUN) && (r_presc == TICK_LAST);

  // Run/pause FSM with prescaler; the prescaler phase survives a pause.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      led_don <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            r_state <= S_RUN;
            r_presc <= '0;
            led_don <= 1'b1;
          end
        end
        S_RUN: begin
          r_presc <= w_tick ? '0 : r_presc + TW'(1);
          if (r_press) begin
            r_state <= S_PAUSE;
            led_don <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (r_press) begin
            r_state <= S_RUN;
            led_don <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          led_don <= 1'b0;
        end
      endcase
    end
  end

  // Next pattern value: reseed on a mode change, otherwise step the current mode.
  always_comb begin
    w_next       = o_reg;
    w_next_dir_l = r_dir_l;
    if (r_sw_s2 != r_cur_mode) begin
      w_next_dir_l = 1'b1;
      case (r_sw_s2)
        M_OFF:      w_next = '0;
        M_WALK_L:   w_next = LSB;
        M_WALK_R:   w_next = MSB;
        M_PINGPONG: w_next = LSB;
        M_COUNT:    w_next = '0;
        M_BLINK:    w_next = '1;
        M_FILL:     w_next = LSB;
        M_ALT:      w_next = ALT_SEED;
      endcase
    end else begin
      case (r_cur_mode)
        M_OFF:    w_next = '0;
        M_WALK_L: w_next = {o_reg[WIDTH-2:0], o_reg[WIDTH-1]};
        M_WALK_R: w_next = {o_reg[0], o_reg[WIDTH-1:1]};
        M_PINGPONG: begin
          // Bounce off either end without repeating the end bit.
          if (r_dir_l) begin
            if (o_reg == MSB) begin
              w_next_dir_l = 1'b0;
              w_next       = MSB >> 1;
            end else begin
              w_next = o_reg << 1;
            end
          end else begin
            if (o_reg == LSB) begin
              w_next_dir_l = 1'b1;
              w_next       = LSB << 1;
            end else begin
              w_next = o_reg >> 1;
            end
          end
        end
        M_COUNT:        w_next = o_reg + WIDTH'(1);
        M_BLINK, M_ALT: w_next = ~o_reg;
        M_FILL:         w_next = (o_reg == '1) ? '0 : {o_reg[WIDTH-2:0], 1'b1};
      endcase
    end
  end

  // Pattern registers move only on a tick.
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      o_reg      <= '0;
      r_cur_mode <= 3'd0;
      r_dir_l    <= 1'b1;
    end else if (w_tick) begin
      o_reg      <= w_next;
      r_cur_mode <= r_sw_s2;
      r_dir_l    <= w_next_dir_l;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: checks led_pattern_ctrl against a behavioural model
// built from the pattern rules, with directed scenarios and random stimulus.
module tb_led_pattern_ctrl;

  localparam int unsigned TICK_DIV     = 5;
  localparam int unsigned DEBOUNCE_CYC = 4;
  localparam int unsigned WIDTH        = 8;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;

  logic             clk_50mhz;
  logic             reset;
  logic             bt;
  logic [2:0]       sw_reg;
  logic [WIDTH-1:0] o_reg;
  logic             led_don;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .WIDTH       (WIDTH)
  ) u_dut (
    .clk_50mhz(clk_50mhz),
    .reset    (reset),
    .bt       (bt),
    .sw_reg   (sw_reg),
    .o_reg    (o_reg),
    .led_don  (led_don)
  );

  initial clk_50mhz = 1'b0;
  always #5 clk_50mhz = ~clk_50mhz;

  // Reference model state
  bit m_valid = 1'b0;
  bit m_bt_a, m_bt_b;
  int m_sw_a, m_sw_b;
  bit m_level;
  int m_disagree;
  bit m_press;
  int m_fsm;
  int m_phase;
  int m_mode;
  bit m_going_left;
  int m_led;
  bit m_don;
  int seed_tab [8] = '{0, 1, 128, 1, 0, 255, 1, 85};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_apply_step(input int sel);
    if (sel != m_mode) begin
      m_mode       = sel;
      m_going_left = 1'b1;
      m_led        = seed_tab[sel];
    end else begin
      case (m_mode)
        1: m_led = (m_led * 2) % 256 + m_led / 128;
        2: m_led = m_led / 2 + (m_led % 2) * 128;
        3: begin
          if (m_going_left) begin
            if (m_led == 128) begin m_going_left = 1'b0; m_led = 64; end
            else m_led = m_led * 2;
          end else begin
            if (m_led == 1) begin m_going_left = 1'b1; m_led = 2; end
            else m_led = m_led / 2;
          end
        end
        4: m_led = (m_led + 1) % 256;
        5, 7: m_led = 255 - m_led;
        6: m_led = (m_led == 255) ? 0 : m_led * 2 + 1;
        default: m_led = 0;
      endcase
    end
  endfunction

  // One clock edge of the model, using values seen just before the edge.
  function automatic void model_edge();
    bit press_seen;
    bit stepping;
    int sel;
    bit synced;
    if (reset) begin
      m_valid = 1'b1;
      m_bt_a = 1'b1; m_bt_b = 1'b1;
      m_sw_a = 0;    m_sw_b = 0;
      m_level = 1'b1; m_disagree = 0; m_press = 1'b0;
      m_fsm = ST_IDLE; m_phase = 0; m_mode = 0; m_going_left = 1'b1;
      m_led = 0; m_don = 1'b0;
      return;
    end
    press_seen = m_press;
    stepping   = (m_fsm == ST_RUN) && (m_phase == int'(TICK_DIV) - 1);
    sel        = m_sw_b;
    synced     = m_bt_b;

    m_press = 1'b0;
    if (synced == m_level) m_disagree = 0;
    else begin
      m_disagree++;
      if (m_disagree == int'(DEBOUNCE_CYC)) begin
        m_press    = (m_level == 1'b1);
        m_level    = synced;
        m_disagree = 0;
      end
    end

    m_bt_b = m_bt_a; m_bt_a = bt;
    m_sw_b = m_sw_a; m_sw_a = int'(sw_reg);

    if (m_fsm == ST_RUN) m_phase = stepping ? 0 : m_phase + 1;
    if (stepping) model_apply_step(sel);

    if (press_seen) begin
      case (m_fsm)
        ST_IDLE:  begin m_fsm = ST_RUN; m_phase = 0; end
        ST_RUN:   m_fsm = ST_PAUSE;
        default:  m_fsm = ST_RUN;
      endcase
    end
    m_don = (m_fsm == ST_RUN);
  endfunction

  // Advance one clock; outputs are compared on the falling edge.
  task automatic cyc();
    @(posedge clk_50mhz);
    model_edge();
    @(negedge clk_50mhz);
    if (m_valid) begin
      check("model_o_reg", 32'(o_reg), 32'(m_led));
      check("model_led_don", 32'(led_don), 32'(m_don));
    end
  endtask

  task automatic press(input int low_cycles);
    bt = 1'b0;
    repeat (low_cycles) cyc();
    bt = 1'b1;
  endtask

  // Wait for the next visible change of o_reg, then check its value.
  task automatic expect_step(input string tag, input logic [7:0] exp);
    logic [7:0] prev;
    int n;
    prev = o_reg;
    n = 0;
    while (o_reg == prev && n < 2 * int'(TICK_DIV) + 2) begin
      cyc();
      n++;
    end
    check(tag, 32'(o_reg), 32'(exp));
  endtask

  task automatic wait_val(input string tag, input logic [7:0] v, input int budget);
    int n;
    n = 0;
    while (o_reg != v && n < budget) begin
      cyc();
      n++;
    end
    check(tag, 32'(o_reg), 32'(v));
  endtask

  initial begin
    int hold;
    reset  = 1'b1;
    bt     = 1'b1;
    sw_reg = 3'd0;

    // Reset state and idle behaviour
    repeat (20) cyc();
    reset = 1'b0;
    repeat (20) cyc();
    check("t1_o_reg", 32'(o_reg), 32'h00);
    check("t1_led_don", 32'(led_don), 32'h0);

    // Walk left with wrap
    sw_reg = 3'd1;
    press(10);
    check("t2_led_don", 32'(led_don), 32'h1);
    for (int i = 0; i < 8; i++) expect_step("t2_walk", 8'(1 << i));
    expect_step("t2_wrap", 8'h01);

    // Ping-pong, both reversals
    sw_reg = 3'd3;
    for (int i = 1; i < 8; i++) expect_step("t3_up", 8'(1 << i));
    for (int i = 6; i >= 0; i--) expect_step("t3_down", 8'(1 << i));
    expect_step("t3_turn", 8'h02);

    // Bounce rejection, then one clean press pauses
    for (int k = 1; k <= 3; k++) begin
      bt = 1'b0;
      repeat (k) cyc();
      bt = 1'b1;
      repeat (6) cyc();
    end
    check("t4_still_run", 32'(led_don), 32'h1);
    press(8);
    repeat (4) cyc();
    check("t4_paused", 32'(led_don), 32'h0);
    repeat (8) cyc();

    // Count mode: pause holds value and prescaler phase
    sw_reg = 3'd4;
    press(8);
    repeat (4) cyc();
    wait_val("t5_reach_06", 8'h06, 200);
    press(8);
    check("t5_pause_val", 32'(o_reg), 32'h07);
    check("t5_pause_don", 32'(led_don), 32'h0);
    for (int i = 0; i < 5; i++) begin
      repeat (10) cyc();
      check("t5_hold_val", 32'(o_reg), 32'h07);
      check("t5_hold_don", 32'(led_don), 32'h0);
    end
    press(8);
    check("t5_resume_don", 32'(led_don), 32'h1);
    check("t5_resume_early", 32'(o_reg), 32'h07);
    expect_step("t5_resume", 8'h08);
    wait_val("t5_reach_ff", 8'hFF, 2000);
    expect_step("t5_wrap", 8'h00);

    // Reset mid-run in fill mode
    sw_reg = 3'd6;
    wait_val("t6_reach_3f", 8'h3F, 200);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    check("t6_rst_o_reg", 32'(o_reg), 32'h00);
    check("t6_rst_don", 32'(led_don), 32'h0);
    reset = 1'b0;
    repeat (20) cyc();
    check("t6_idle_o_reg", 32'(o_reg), 32'h00);
    check("t6_idle_don", 32'(led_don), 32'h0);
    press(8);
    expect_step("t6_first_tick", 8'h01);

    // Random button activity, mode changes and occasional resets
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        bt   = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if ($urandom_range(0, 29) == 0) sw_reg = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset = 1'b0;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
